cga_pixel_shifter: RTL

- Text/hi-res pixel serializer directly upstream of the RGBI-to-RGB colour stage.
- Takes one font/bitmap byte plus attribute per character cell and shifts out one RGBI pixel per pixel-clock enable.
- Applies attribute decode, character blink, cursor overlay, border colour and blanking.
- Outputs r_out/g_out/b_out/i_out feed the colour stage's r_in/g_in/b_in/i_in one-to-one.

---
 rtl/cga_pixel_shifter_if.sv | 31 +++
 rtl/cga_pixel_shifter.sv | 88 ++++++++
 2 files changed

// File: rtl/cga_pixel_shifter_if.sv
// Character-cell inputs and RGBI pixel outputs of the CGA pixel shifter.
// The master drives cell data and timing; the slave is the shifter itself.
interface cga_pixel_shifter_if;
    logic       pix_en;
    logic       load;
    logic [7:0] char_bits;
    logic [7:0] attr;
    logic       cursor;
    logic       disp_en;
    logic       blank;
    logic       vsync;
    logic       mode_hires;
    logic       blink_en;
    logic [3:0] color_sel;
    logic       r_out;
    logic       g_out;
    logic       b_out;
    logic       i_out;

    modport master (
        output pix_en, load, char_bits, attr, cursor, disp_en, blank, vsync,
               mode_hires, blink_en, color_sel,
        input  r_out, g_out, b_out, i_out
    );

    modport slave (
        input  pix_en, load, char_bits, attr, cursor, disp_en, blank, vsync,
               mode_hires, blink_en, color_sel,
        output r_out, g_out, b_out, i_out
    );
endinterface

// File: rtl/cga_pixel_shifter.sv
// Text/hi-res pixel serializer: shifts one font byte per cell out as RGBI pixels,
// applying attribute decode, blink, cursor overlay, border colour and blanking.
module cga_pixel_shifter #(
    parameter int unsigned CURSOR_BLINK_BIT = 3,
    parameter int unsigned CHAR_BLINK_BIT   = 4,
    parameter int unsigned FCNT_W           = 5
) (
    input logic                clk,
    input logic                rst,
    cga_pixel_shifter_if.slave bus
);

    logic [7:0]        r_shreg;
    logic [7:0]        r_attr;
    logic              r_cursor;
    logic              r_disp_en;
    logic [3:0]        r_irgb;
    logic [FCNT_W-1:0] r_fcnt;
    logic              r_vsync_d;

    logic       w_pixel;
    logic       w_blink_hide;
    logic       w_cursor_on;
    logic       w_fg_on;
    logic [3:0] w_bg;
    logic [3:0] w_text;
    logic [3:0] w_next_irgb;

    // Frame counter runs on the raw clock so no vsync edge is lost between pixel enables.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vsync_d <= 1'b0;
            r_fcnt    <= '0;
        end else begin
            r_vsync_d <= bus.vsync;
            if (bus.vsync && !r_vsync_d) begin
                r_fcnt <= r_fcnt + FCNT_W'(1);
            end
        end
    end

    assign w_pixel      = r_shreg[7];
    assign w_blink_hide = bus.blink_en & r_attr[7] & r_fcnt[CHAR_BLINK_BIT];
    assign w_cursor_on  = r_cursor & r_fcnt[CURSOR_BLINK_BIT];
    assign w_fg_on      = (w_pixel & ~w_blink_hide) | w_cursor_on;
    assign w_bg         = bus.blink_en ? {1'b0, r_attr[6:4]} : r_attr[7:4];
    assign w_text       = w_fg_on ? r_attr[3:0] : w_bg;

    always_comb begin
        w_next_irgb = 4'h0;
        if (bus.blank) begin
            w_next_irgb = 4'h0;
        end else if (!r_disp_en) begin
            w_next_irgb = bus.color_sel;
        end else if (bus.mode_hires) begin
            w_next_irgb = w_pixel ? bus.color_sel : 4'h0;
        end else begin
            w_next_irgb = w_text;
        end
    end

    // Output sees the pre-edge shifter/cell state, giving one enable of latency after a load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg   <= 8'h00;
            r_attr    <= 8'h00;
            r_cursor  <= 1'b0;
            r_disp_en <= 1'b0;
            r_irgb    <= 4'h0;
        end else if (bus.pix_en) begin
            r_irgb <= w_next_irgb;
            if (bus.load) begin
                r_shreg   <= bus.char_bits;
                r_attr    <= bus.attr;
                r_cursor  <= bus.cursor;
                r_disp_en <= bus.disp_en;
            end else begin
                r_shreg <= {r_shreg[6:0], 1'b0};
            end
        end
    end

    assign bus.i_out = r_irgb[3];
    assign bus.r_out = r_irgb[2];
    assign bus.g_out = r_irgb[1];
    assign bus.b_out = r_irgb[0];

endmodule
